// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// funct3 encodings, FSM state encoding, step mode and operand magnitude helper.
package muldiv_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    mag = neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage control and the multiply/divide unit.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output busy, done, result
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// Purely combinational; the caller reassembles the low word from q_bit.
module muldiv_step
  import muldiv_unit_pkg::*;
(
  input  mode_e           mode,
  input  logic [XLEN-1:0] acc_hi,
  input  logic            lo_bit,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_hi_next,
  output logic            q_bit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum         = '0;
    shifted     = '0;
    diff        = '0;
    acc_hi_next = acc_hi;
    q_bit       = 1'b0;
    if (mode == MODE_MUL) begin
      // lo_bit is the current multiplier LSB; sum[0] drops into the low word's MSB
      sum         = {1'b0, acc_hi} + (lo_bit ? {1'b0, operand} : '0);
      acc_hi_next = sum[XLEN:1];
      q_bit       = sum[0];
    end else begin
      // borrow out of the 33-bit subtract means the trial subtraction fails
      shifted = {acc_hi, lo_bit};
      diff    = shifted - {1'b0, operand};
      if (!diff[XLEN]) begin
        acc_hi_next = diff[XLEN-1:0];
        q_bit       = 1'b1;
      end else begin
        acc_hi_next = shifted[XLEN-1:0];
        q_bit       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: done pulses 34 cycles after an accepted start
// (1 cycle for divide-by-zero and signed overflow); busy stalls upstream meanwhile.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  mode_e           step_mode;
  logic            step_lo_bit;
  logic [XLEN-1:0] step_hi_next;
  logic            step_q_bit;

  assign step_mode   = mode_e'(f3_q[2]);
  assign step_lo_bit = f3_q[2] ? acc_q[XLEN-1] : acc_q[0];

  muldiv_step u_step (
    .mode        (step_mode),
    .acc_hi      (acc_q[2*XLEN-1:XLEN]),
    .lo_bit      (step_lo_bit),
    .operand     (opb_q),
    .acc_hi_next (step_hi_next),
    .q_bit       (step_q_bit)
  );

  logic              sa, sb;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [2*XLEN-1:0] mul_s;
  logic [XLEN-1:0]   q_s, r_s, res_fin;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    sa = bus.rs1[XLEN-1] & (bus.funct3 != F3_MULHU) & (bus.funct3 != F3_DIVU)
                         & (bus.funct3 != F3_REMU);
    sb = bus.rs2[XLEN-1] & ((bus.funct3 == F3_MUL) | (bus.funct3 == F3_MULH)
                         |  (bus.funct3 == F3_DIV) | (bus.funct3 == F3_REM));
    a_abs = mag(bus.rs1, sa);
    b_abs = mag(bus.rs2, sb);

    mul_s = neg_q ? (~acc_q + 1'b1) : acc_q;
    q_s   = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    r_s   = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:           res_fin = mul_s[XLEN-1:0];
      F3_DIV, F3_DIVU:  res_fin = q_s;
      F3_REM, F3_REMU:  res_fin = r_s;
      default:          res_fin = mul_s[2*XLEN-1:XLEN];
    endcase

    case (state_q)
      ST_IDLE: begin
        // done_q marks the completion cycle, where a new start is dropped
        if (bus.start && !bus.flush && !done_q) begin
          if (bus.funct3[2] && bus.rs2 == '0) begin
            done_d   = 1'b1;
            result_d = bus.funct3[1] ? bus.rs1 : '1;
          end else if ((bus.funct3 == F3_DIV || bus.funct3 == F3_REM)
                       && bus.rs1 == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2 == '1) begin
            done_d   = 1'b1;
            result_d = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          end else begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
            cnt_d   = '0;
            f3_d    = bus.funct3;
            neg_d   = (bus.funct3[2] & bus.funct3[1]) ? sa : (sa ^ sb);
            if (bus.funct3[2]) begin
              opb_d = b_abs;
              acc_d = {{XLEN{1'b0}}, a_abs};
            end else begin
              opb_d = a_abs;
              acc_d = {{XLEN{1'b0}}, b_abs};
            end
          end
        end
      end
      ST_CALC: begin
        if (f3_q[2]) acc_d = {step_hi_next, acc_q[XLEN-2:0], step_q_bit};
        else         acc_d = {step_hi_next, step_q_bit, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {CNT_W{1'b1}}) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = res_fin;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (bus.flush && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: op results, latency, busy window, flush/reset/start-ignore cases.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; start is presented for exactly one cycle.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat, ndone, busy_bad;
    logic [31:0] res_at_done;
    lat = -1; ndone = 0; busy_bad = 0; res_at_done = 'x;
    bus.start = 1'b1; bus.funct3 = f3; bus.rs1 = a; bus.rs2 = b;
    for (int c = 1; c <= exp_lat + 6; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.rs1 = $urandom(); bus.rs2 = $urandom();
      if (bus.done === 1'b1) begin
        ndone++;
        if (lat < 0) begin lat = c; res_at_done = bus.result; end
      end
      if (bus.busy !== (c < exp_lat)) busy_bad++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " done count"}, ndone, 1);
    check({tag, " result"}, res_at_done, exp_res);
    check({tag, " busy window"}, busy_bad, 0);
    check({tag, " result held"}, bus.result, exp_res);
  endtask

  initial begin
    int ndone, busy_bad, d1, d2;
    logic [31:0] r1, r2, prev;
    logic busy_before;

    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.rs1 = '0; bus.rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset result", bus.result, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("MUL 7*-3",      F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("MULH min*min",  F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
    run_op("MULHU max*max", F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("MULHSU -1*2",   F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34);
    run_op("DIV -7/2",      F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run_op("REM -7,2",      F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    run_op("DIVU 100/7",    F3_DIVU,   32'd100,        32'd7,         32'd14,        34);
    run_op("REMU 100,7",    F3_REMU,   32'd100,        32'd7,         32'd2,         34);
    run_op("DIVU 5/0",      F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("REM 5,0",       F3_REM,    32'd5,          32'd0,         32'd5,         1);
    run_op("DIV ovf",       F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf",       F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);
    run_op("REMU 100,7 b",  F3_REMU,   32'd100,        32'd7,         32'd2,         34);

    // start during busy (t+5) and during the done cycle (t+34) is dropped; t+35 is taken
    ndone = 0; d1 = -1; d2 = -1; r1 = 'x; r2 = 'x;
    bus.start = 1'b1; bus.funct3 = F3_MUL; bus.rs1 = 32'd7; bus.rs2 = 32'hFFFF_FFFD;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (d1 < 0) begin d1 = c; r1 = bus.result; end
        else if (d2 < 0) begin d2 = c; r2 = bus.result; end
      end
      if (c == 5 || c == 34) begin
        bus.start = 1'b1; bus.funct3 = F3_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
      end
      if (c == 35) begin
        bus.start = 1'b1; bus.funct3 = F3_MULHU; bus.rs1 = 32'hFFFF_FFFF; bus.rs2 = 32'hFFFF_FFFF;
      end
    end
    check("b2b done count", ndone, 2);
    check("b2b first done cycle", d1, 34);
    check("b2b first result", r1, 32'hFFFF_FFEB);
    check("b2b second done cycle", d2, 69);
    check("b2b second result", r2, 32'hFFFF_FFFE);

    // flush and start together in IDLE: start is dropped
    prev = bus.result;
    ndone = 0; busy_bad = 0;
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = F3_MUL; bus.rs1 = 32'd3; bus.rs2 = 32'd3;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      if (bus.done === 1'b1) ndone++;
      if (bus.busy !== 1'b0) busy_bad++;
    end
    check("flush+start no done", ndone, 0);
    check("flush+start no busy", busy_bad, 0);
    check("flush+start result", bus.result, prev);

    // flush at t+10 of a DIV
    ndone = 0; busy_bad = 0; busy_before = 1'b0;
    bus.start = 1'b1; bus.funct3 = F3_DIV; bus.rs1 = 32'hFFFF_FFF9; bus.rs2 = 32'd2;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      if (bus.done === 1'b1) ndone++;
      if (c >= 11 && bus.busy !== 1'b0) busy_bad++;
      if (c == 10) begin busy_before = bus.busy; bus.flush = 1'b1; end
    end
    check("flush busy before", busy_before, 1'b1);
    check("flush no done", ndone, 0);
    check("flush busy cleared", busy_bad, 0);
    check("flush result kept", bus.result, prev);

    // reset at t+20 of a DIVU
    ndone = 0;
    bus.start = 1'b1; bus.funct3 = F3_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) ndone++;
      if (c == 20) rst = 1'b1;
    end
    check("rst mid-op result", bus.result, 32'h0);
    check("rst mid-op busy", bus.busy, 1'b0);
    check("rst mid-op no done", ndone, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("DIVU after rst", F3_DIVU, 32'd100, 32'd7, 32'd14, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
